// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin owner sequencer for a shared tri-state bus
// Grants one driver at a time and keeps every oe low for TA_CYCLES between owners.
module tri_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TA_CYCLES = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TA_W   = $clog2(TA_CYCLES + 1);

    localparam logic [N_REQ-1:0]  ONE      = N_REQ'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [TA_W-1:0]   TA_LAST  = TA_W'(TA_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TA_W-1:0]   ta_cnt;

    logic [N_REQ-1:0]  hi_mask;
    logic [N_REQ-1:0]  hi_req;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              owner_req;
    logic              release_now;
    logic [IDX_W-1:0]  next_ptr;

    // Requests at or above rr_ptr take priority; otherwise the search wraps to bit 0.
    assign hi_mask = ~((ONE << rr_ptr) - ONE);
    assign hi_req  = req & hi_mask;

    always_comb begin
        win_found = |req;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign owner_req   = req[owner];
    assign release_now = !owner_req || (hold_cnt == HOLD_MAX);
    assign next_ptr    = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            timeout  <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            ta_cnt   <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt      <= ONE << win_idx;
                        owner    <= win_idx;
                        hold_cnt <= HOLD_W'(1);
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt     <= '0;
                        rr_ptr  <= next_ptr;
                        ta_cnt  <= TA_W'(1);
                        // A still-requesting owner here was cut off by the hold limit.
                        timeout <= owner_req;
                        state   <= TURN;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                TURN: begin
                    if (ta_cnt == TA_LAST) begin
                        if (win_found) begin
                            gnt      <= ONE << win_idx;
                            owner    <= win_idx;
                            hold_cnt <= HOLD_W'(1);
                            state    <= GRANT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        ta_cnt <= ta_cnt + TA_W'(1);
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign oe   = gnt;
    assign busy = |gnt;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - directed and random checks of tri_bus_arbiter against a behavioural model
// Two instances share clock/reset: dut_a uses TA_CYCLES=1, dut_b uses TA_CYCLES=2.
module tb_tri_bus_arbiter;

    localparam int N     = 4;
    localparam int MH    = 16;
    localparam int BOUND = N * (MH + 2);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
    logic [1:0] owner_a, owner_b;
    logic       busy_a, timeout_a, busy_b, timeout_b;
    tri   [7:0] bus_a, bus_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_REQ(N), .TA_CYCLES(1), .MAX_HOLD(MH)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .oe(oe_a),
        .owner(owner_a), .busy(busy_a), .timeout(timeout_a)
    );

    tri_bus_arbiter #(.N_REQ(N), .TA_CYCLES(2), .MAX_HOLD(MH)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .oe(oe_b),
        .owner(owner_b), .busy(busy_b), .timeout(timeout_b)
    );

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_drv
            localparam logic [7:0] D = 8'hA0 + 8'(g);
            assign bus_a = oe_a[g] ? D : 8'hzz;
            assign bus_b = oe_b[g] ? D : 8'hzz;
        end
    endgenerate

    // Behavioural model: who holds the bus, for how long, and how long it has been quiet.
    int m_cur[2];
    int m_held[2];
    int m_quiet[2];
    int m_last[2];
    int m_ptr[2];
    bit m_to[2];

    task automatic m_reset(input int k);
        m_cur[k]   = -1;
        m_held[k]  = 0;
        m_quiet[k] = 1000;
        m_last[k]  = 0;
        m_ptr[k]   = 0;
        m_to[k]    = 1'b0;
    endtask

    task automatic m_step(input int k, input logic [3:0] r, input int ta);
        int c;
        int w;
        m_to[k] = 1'b0;
        if (m_cur[k] >= 0) begin
            c = m_cur[k];
            if (!r[c] || m_held[k] == MH) begin
                m_to[k]    = r[c];
                m_ptr[k]   = (c + 1) % N;
                m_cur[k]   = -1;
                m_quiet[k] = 1;
            end else begin
                m_held[k]++;
            end
        end else if (m_quiet[k] >= ta && r != 4'b0000) begin
            w = -1;
            for (int j = 0; j < N; j++) begin
                if (w < 0 && r[(m_ptr[k] + j) % N]) w = (m_ptr[k] + j) % N;
            end
            m_cur[k]  = w;
            m_last[k] = w;
            m_held[k] = 1;
        end else if (m_quiet[k] < 1000) begin
            m_quiet[k]++;
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int k);
        return (m_cur[k] >= 0) ? (4'b0001 << m_cur[k]) : 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_reset(0);
        m_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset(0);
                m_reset(1);
            end else begin
                m_step(0, req_a, 1);
                m_step(1, req_b, 2);
            end
        end
    end

    int wait_a[4];
    int wait_b[4];

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        for (int i = 0; i < 4; i++) begin
            wait_a[i] = 0;
            wait_b[i] = 0;
        end
        forever begin
            @(negedge clk);
            chk("gnt_a", 32'(gnt_a), 32'(exp_gnt(0)));
            chk("oe_a", 32'(oe_a), 32'(exp_gnt(0)));
            chk("owner_a", 32'(owner_a), 32'(m_last[0]));
            chk("busy_a", 32'(busy_a), 32'(m_cur[0] >= 0));
            chk("timeout_a", 32'(timeout_a), 32'(m_to[0]));
            chk("onehot_a", 32'($onehot0(oe_a)), 32'd1);
            chk("gnt_b", 32'(gnt_b), 32'(exp_gnt(1)));
            chk("oe_b", 32'(oe_b), 32'(exp_gnt(1)));
            chk("owner_b", 32'(owner_b), 32'(m_last[1]));
            chk("busy_b", 32'(busy_b), 32'(m_cur[1] >= 0));
            chk("timeout_b", 32'(timeout_b), 32'(m_to[1]));
            chk("onehot_b", 32'($onehot0(oe_b)), 32'd1);
            if (m_cur[0] >= 0) chk("bus_a", 32'(bus_a), 32'(8'hA0 + m_cur[0]));
            if (m_cur[1] >= 0) chk("bus_b", 32'(bus_b), 32'(8'hA0 + m_cur[1]));
            for (int i = 0; i < 4; i++) begin
                if (gnt_a[i] && wait_a[i] > 0) chk("wait_a", 32'(wait_a[i] <= BOUND), 32'd1);
                if (gnt_b[i] && wait_b[i] > 0) chk("wait_b", 32'(wait_b[i] <= BOUND), 32'd1);
                wait_a[i] = (req_a[i] && !gnt_a[i]) ? wait_a[i] + 1 : 0;
                wait_b[i] = (req_b[i] && !gnt_b[i]) ? wait_b[i] + 1 : 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int cnt;
    int to_cnt;
    int run;
    int idle;
    bit prev_busy;
    int order[$];
    int stints[$];
    int gaps[$];
    int hc[4];
    bit pend[4];

    initial begin
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_b = 4'b0000;

        // 1: held in reset with all requests, then first grant goes to requester 0.
        tick();
        tick();
        chk("t1_gnt_in_reset", 32'(gnt_a), 32'd0);
        chk("t1_busy_in_reset", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t1_first_grant", 32'(gnt_a), 32'b0001);

        // 2: single requester for 5 cycles.
        req_a = 4'b0000;
        do_reset();
        req_a = 4'b0100;
        cnt = 0;
        repeat (5) begin
            tick();
            if (gnt_a == 4'b0100 && owner_a == 2'd2) cnt++;
        end
        req_a = 4'b0000;
        chk("t2_grant_cycles", 32'(cnt), 32'd5);
        tick();
        chk("t2_turn_gnt", 32'(gnt_a), 32'd0);
        tick();
        chk("t2_idle_gnt", 32'(gnt_a), 32'd0);
        chk("t2_owner_kept", 32'(owner_a), 32'd2);

        // 3: all request; each owner drops 3 cycles after grant, re-raises a cycle later.
        do_reset();
        req_a = 4'b1111;
        prev_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hc[i] = 0;
            pend[i] = 1'b0;
        end
        repeat (22) begin
            tick();
            if (busy_a && !prev_busy) order.push_back(int'(owner_a));
            prev_busy = busy_a;
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    req_a[i] = 1'b1;
                    pend[i] = 1'b0;
                end else if (gnt_a[i]) begin
                    hc[i]++;
                    if (hc[i] == 3) begin
                        req_a[i] = 1'b0;
                        hc[i] = 0;
                        pend[i] = 1'b1;
                    end
                end
            end
        end
        chk("t3_grant_count", 32'(order.size() >= 5), 32'd1);
        if (order.size() >= 5) begin
            chk("t3_order0", 32'(order[0]), 32'd0);
            chk("t3_order1", 32'(order[1]), 32'd1);
            chk("t3_order2", 32'(order[2]), 32'd2);
            chk("t3_order3", 32'(order[3]), 32'd3);
            chk("t3_order4", 32'(order[4]), 32'd0);
        end

        // 4: lone requester held for 40 cycles hits the hold limit.
        req_a = 4'b0000;
        do_reset();
        req_a = 4'b0010;
        run = 0;
        idle = 0;
        to_cnt = 0;
        repeat (40) begin
            tick();
            if (timeout_a) to_cnt++;
            if (gnt_a[1]) begin
                if (run == 0 && stints.size() > 0) gaps.push_back(idle);
                run++;
                idle = 0;
            end else begin
                if (run > 0) stints.push_back(run);
                run = 0;
                idle++;
            end
        end
        req_a = 4'b0000;
        chk("t4_stints_seen", 32'(stints.size() >= 2 && gaps.size() >= 1), 32'd1);
        if (stints.size() >= 2 && gaps.size() >= 1) begin
            chk("t4_stint0", 32'(stints[0]), 32'd16);
            chk("t4_stint1", 32'(stints[1]), 32'd16);
            chk("t4_gap0", 32'(gaps[0]), 32'd1);
        end
        chk("t4_timeouts", 32'(to_cnt), 32'd2);

        // 5: reset asserted between edges while a grant is active.
        do_reset();
        req_a = 4'b0001;
        tick();
        tick();
        tick();
        chk("t5_granted", 32'(oe_a), 32'b0001);
        rst_n = 1'b0;
        #1;
        chk("t5_oe_async", 32'(oe_a), 32'd0);
        chk("t5_busy_async", 32'(busy_a), 32'd0);
        chk("t5_timeout_async", 32'(timeout_a), 32'd0);
        tick();
        tick();
        chk("t5_gnt_held_reset", 32'(gnt_a), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_gnt_before_edge", 32'(gnt_a), 32'd0);
        tick();
        chk("t5_regrant", 32'(gnt_a), 32'b0001);

        // 6: random requests, held until served, on both instances.
        req_a = 4'b0000;
        do_reset();
        repeat (5000) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (req_a[i]) begin
                    if (gnt_a[i] && $urandom_range(5) == 0) req_a[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req_a[i] = 1'b1;
                end
                if (req_b[i]) begin
                    if (gnt_b[i] && $urandom_range(5) == 0) req_b[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req_b[i] = 1'b1;
                end
            end
        end
        req_a = 4'b0000;
        req_b = 4'b0000;
        repeat (5) tick();
        chk("t6_idle_a", 32'(busy_a), 32'd0);
        chk("t6_idle_b", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
